// File: rtl/port_led_viewer.sv
// port_led_viewer
//   Maps the processor's output ports onto the board LEDs. One LED_WIDTH-bit
//   slice of one selected channel is shown on led. Three raw push-buttons are
//   synchronised and debounced. They step the channel, step the slice, and
//   toggle freeze, which holds the display.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   port_in     CHANNELS packed ports; channel i is port_in[i*WIDTH +: WIDTH]
//   btn_next    raw button, a press advances the channel
//   btn_slice   raw button, a press advances the slice
//   btn_freeze  raw button, a press toggles freeze
//   led         registered display value
//   sel_channel current channel index
//   sel_slice   current slice index
//   frozen      high while the display is held
//
// There is no valid/ready handshake here. Buttons are level inputs, and a
// press becomes a single-cycle pulse on the rising edge of the debounced
// level.
module port_led_viewer #(
    parameter int WIDTH           = 32,
    parameter int CHANNELS        = 4,
    parameter int LED_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    localparam int SLICES = (WIDTH + LED_WIDTH - 1) / LED_WIDTH,
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int SL_W   = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] port_in,
    input  logic                      btn_next,
    input  logic                      btn_slice,
    input  logic                      btn_freeze,
    output logic [LED_WIDTH-1:0]      led,
    output logic [CH_W-1:0]           sel_channel,
    output logic [SL_W-1:0]           sel_slice,
    output logic                      frozen
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button vector order: bit 0 next, bit 1 slice, bit 2 freeze.
    logic [2:0]       btn_raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       st;
    logic [2:0]       st_q;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];

    assign btn_raw = {btn_freeze, btn_slice, btn_next};

    // s1 is only ever read by s2. Keeping it that way keeps the synchroniser
    // a clean two-flop chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            st   <= '0;
            st_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            st_q <= st;
            for (int i = 0; i < 3; i++) begin
                // Any sample that agrees with the stable level restarts the
                // count. A bounce therefore needs a fresh run of samples.
                if (s2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    st[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Only rising edges of the debounced level count; releases are ignored.
    assign press = st & ~st_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_channel <= '0;
            sel_slice   <= '0;
            frozen      <= 1'b0;
        end else begin
            // Pulses on the same cycle are applied independently.
            if (press[0]) begin
                sel_channel <= (sel_channel == CH_W'(CHANNELS - 1)) ? '0
                                                                     : sel_channel + CH_W'(1);
            end
            if (press[1]) begin
                sel_slice <= (sel_slice == SL_W'(SLICES - 1)) ? '0
                                                              : sel_slice + SL_W'(1);
            end
            if (press[2]) begin
                frozen <= ~frozen;
            end
        end
    end

    // The selected channel word is zero-extended to a whole number of slices,
    // so a partial top slice reads zeros above WIDTH.
    logic [WIDTH-1:0]            chan_word;
    logic [SLICES*LED_WIDTH-1:0] padded;
    logic [LED_WIDTH-1:0]        slice_word;

    always_comb begin
        chan_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_channel == CH_W'(i)) begin
                chan_word = port_in[i*WIDTH +: WIDTH];
            end
        end
        padded     = (SLICES*LED_WIDTH)'(chan_word);
        slice_word = '0;
        for (int j = 0; j < SLICES; j++) begin
            if (sel_slice == SL_W'(j)) begin
                slice_word = padded[j*LED_WIDTH +: LED_WIDTH];
            end
        end
    end

    // The current value of frozen gates the sample. On the edge where frozen
    // rises, led still samples, and that sample is the one that gets held.
    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else if (!frozen) begin
            led <= slice_word;
        end
    end

endmodule

// File: tb/tb_port_led_viewer.sv
module tb_port_led_viewer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance: WIDTH=32, full slices.
    logic [127:0] port_in;
    logic         btn_next, btn_slice, btn_freeze;
    logic [15:0]  led;
    logic [1:0]   sel_channel;
    logic [0:0]   sel_slice;
    logic         frozen;

    port_led_viewer #(
        .WIDTH(32), .CHANNELS(4), .LED_WIDTH(16), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .port_in(port_in),
        .btn_next(btn_next), .btn_slice(btn_slice), .btn_freeze(btn_freeze),
        .led(led), .sel_channel(sel_channel), .sel_slice(sel_slice), .frozen(frozen)
    );

    // Second instance: WIDTH=24, so the top slice is partial.
    logic [95:0]  port_in2;
    logic         btn2_next, btn2_slice, btn2_freeze;
    logic [15:0]  led2;
    logic [1:0]   sel_channel2;
    logic [0:0]   sel_slice2;
    logic         frozen2;

    port_led_viewer #(
        .WIDTH(24), .CHANNELS(4), .LED_WIDTH(16), .DEBOUNCE_CYCLES(4)
    ) dut2 (
        .clk(clk), .reset(reset), .port_in(port_in2),
        .btn_next(btn2_next), .btn_slice(btn2_slice), .btn_freeze(btn2_freeze),
        .led(led2), .sel_channel(sel_channel2), .sel_slice(sel_slice2), .frozen(frozen2)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_next   = v;
            1: btn_slice  = v;
            2: btn_freeze = v;
            3: btn2_next  = v;
            default: btn2_slice = v;
        endcase
    endtask

    // Hold long enough for the debounce to accept the press, then release and
    // let the release settle.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        tick(8);
        set_btn(which, 1'b0);
        tick(10);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        btn_next = 0; btn_slice = 0; btn_freeze = 0;
        btn2_next = 0; btn2_slice = 0; btn2_freeze = 0;
        port_in  = {32'h4444DDDD, 32'h3333CCCC, 32'h2222BBBB, 32'h1111AAAA};
        port_in2 = {24'h44DDDD, 24'h33CCCC, 24'h22BBBB, 24'h11AAAA};
        tick(2);
        check_val("rst_led", 32'(led), 32'h0);
        check_val("rst_ch", 32'(sel_channel), 32'h0);
        check_val("rst_sl", 32'(sel_slice), 32'h0);
        check_val("rst_frz", 32'(frozen), 32'h0);
        reset = 1'b0;
        tick(10);
        check_val("idle_led", 32'(led), 32'hAAAA);
        check_val("idle_ch", 32'(sel_channel), 32'h0);

        // Latency: edge 0 samples the button, selection moves on edge 6.
        btn_next = 1'b1;
        tick(6);
        check_val("lat_ch_before", 32'(sel_channel), 32'h0);
        tick(1);
        check_val("lat_ch_after", 32'(sel_channel), 32'h1);
        check_val("lat_led_before", 32'(led), 32'hAAAA);
        tick(1);
        check_val("lat_led_after", 32'(led), 32'hBBBB);
        tick(12);
        btn_next = 1'b0;
        tick(10);
        check_val("hold_no_repeat", 32'(sel_channel), 32'h1);

        // Wrap sequence.
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        while (exp_q.size() > 0) begin
            press(0);
            check_val("wrap_ch", 32'(sel_channel), exp_q.pop_front());
        end

        // Slices on channel C.
        press(0);
        check_val("c_led", 32'(led), 32'hCCCC);
        press(1);
        check_val("c_slice1_sel", 32'(sel_slice), 32'h1);
        check_val("c_slice1_led", 32'(led), 32'h3333);
        press(1);
        check_val("c_slice_wrap", 32'(sel_slice), 32'h0);
        check_val("c_slice0_led", 32'(led), 32'hCCCC);

        // Bounce: 2-cycle toggling never accumulates 4 stable samples.
        for (int k = 0; k < 20; k++) begin
            btn_next = ~btn_next;
            tick(2);
        end
        btn_next = 1'b0;
        tick(10);
        check_val("bounce2_ch", 32'(sel_channel), 32'h2);
        // 3-cycle toggling is still too short; a final steady high steps once.
        for (int k = 0; k < 14; k++) begin
            btn_next = ~btn_next;
            tick(3);
        end
        check_val("bounce3_ch", 32'(sel_channel), 32'h2);
        btn_next = 1'b1;
        tick(10);
        check_val("bounce3_step", 32'(sel_channel), 32'h3);
        btn_next = 1'b0;
        tick(10);
        check_val("bounce3_release", 32'(sel_channel), 32'h3);

        // Freeze on channel A.
        press(0);
        check_val("a_led", 32'(led), 32'hAAAA);
        press(2);
        check_val("frz_on", 32'(frozen), 32'h1);
        port_in[31:0] = 32'h12345678;
        tick(3);
        check_val("frz_hold", 32'(led), 32'hAAAA);
        press(0);
        press(0);
        check_val("frz_ch", 32'(sel_channel), 32'h2);
        check_val("frz_led", 32'(led), 32'hAAAA);
        btn_freeze = 1'b1;
        tick(7);
        check_val("unfrz", 32'(frozen), 32'h0);
        check_val("unfrz_led_hold", 32'(led), 32'hAAAA);
        tick(1);
        check_val("unfrz_led_new", 32'(led), 32'hCCCC);
        btn_freeze = 1'b0;
        tick(10);

        // Simultaneous next + freeze land on the same edge.
        btn_next = 1'b1;
        btn_freeze = 1'b1;
        tick(6);
        check_val("sim_ch_before", 32'(sel_channel), 32'h2);
        check_val("sim_frz_before", 32'(frozen), 32'h0);
        tick(1);
        check_val("sim_ch_after", 32'(sel_channel), 32'h3);
        check_val("sim_frz_after", 32'(frozen), 32'h1);
        btn_next = 1'b0;
        btn_freeze = 1'b0;
        tick(10);
        press(2);
        check_val("sim_unfrz_led", 32'(led), 32'hDDDD);

        // Reset in the middle of a debounce count.
        btn_next = 1'b1;
        tick(4);
        reset = 1'b1;
        btn_next = 1'b0;
        tick(1);
        check_val("midrst_led", 32'(led), 32'h0);
        reset = 1'b0;
        tick(12);
        check_val("midrst_ch", 32'(sel_channel), 32'h0);
        check_val("midrst_frz", 32'(frozen), 32'h0);
        check_val("midrst_led_after", 32'(led), 32'h5678);

        // Partial top slice on the WIDTH=24 instance, channel D.
        press(3);
        press(3);
        press(3);
        check_val("w24_ch", 32'(sel_channel2), 32'h3);
        check_val("w24_led0", 32'(led2), 32'hDDDD);
        press(4);
        check_val("w24_led1", 32'(led2), 32'h0044);
        press(4);
        check_val("w24_wrap", 32'(led2), 32'hDDDD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
